// File: rtl/pio_fifo_pkg.sv
// -----------------------------------------------------------------------------
// pio_fifo_pkg
// Shared definitions for the PIO FIFO push-side logic.
//   - Packer FSM state encodings (2-bit, legacy-compatible constants)
//   - FIFO PUSH_FLAG level constants
//   - hold_t: the word held by the packer while its halves are pushed
//   - pick_half(): selects the upper or lower 16 bits of a 32-bit word
// -----------------------------------------------------------------------------
package pio_fifo_pkg;

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;

  localparam logic [3:0] FLAG_FULL = 4'h0;
  localparam logic [3:0] FLAG_ONE  = 4'h1;

  typedef struct packed {
    logic        half;
    logic [31:0] data;
  } hold_t;

  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/fifo_push_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_push_packer_if
// Bundles the upstream 32-bit valid/ready stream and the FIFO push-side
// signals seen by fifo_push_packer.
//   in_valid/in_ready/in_data/in_half : upstream word stream
//   PUSH_FLAG                          : FIFO push-side fill level
//   DIN/PUSH/Fifo_Push_Flush           : FIFO write port and flush
// Modports:
//   master : the environment (upstream source + FIFO)
//   slave  : the packer
// -----------------------------------------------------------------------------
interface fifo_push_packer_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_half;
  logic [3:0]  PUSH_FLAG;
  logic [15:0] DIN;
  logic        PUSH;
  logic        Fifo_Push_Flush;

  modport master (
    output in_valid,
    output in_data,
    output in_half,
    output PUSH_FLAG,
    input  in_ready,
    input  DIN,
    input  PUSH,
    input  Fifo_Push_Flush
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_half,
    input  PUSH_FLAG,
    output in_ready,
    output DIN,
    output PUSH,
    output Fifo_Push_Flush
  );

endinterface

// File: rtl/fifo_push_packer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   Clk  : clock
//   Rst  : synchronous active-high reset, clears the count
//   inc  : add one this cycle (ignored once saturated)
//   clr  : synchronous clear
//   cnt  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/fifo_push_packer.sv
// -----------------------------------------------------------------------------
// fifo_push_packer
// Upstream feeder for the 1024x16 PIO FIFO. Accepts 32-bit words on a
// valid/ready stream and pushes them into the FIFO as two 16-bit writes
// (or one, when in_half is set), throttled by the FIFO PUSH_FLAG level.
// Also owns the FIFO push-side flush and keeps push/stall statistics.
//
// Parameters:
//   HI_FIRST : 0 pushes [15:0] then [31:16]; 1 pushes [31:16] then [15:0]
//   CNT_W    : width of the saturating statistics counters
//
// Ports:
//   Clk       : single clock, shared with the FIFO
//   Rst       : synchronous active-high reset
//   bus       : stream + FIFO push interface (slave modport)
//   flush_req : single-cycle software flush request
//   busy      : a half-word is still pending
//   push_cnt  : 16-bit words pushed (saturating)
//   stall_cnt : cycles with a half pending but no push allowed (saturating)
// -----------------------------------------------------------------------------
module fifo_push_packer
  import pio_fifo_pkg::*;
#(
  parameter bit HI_FIRST = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  fifo_push_packer_if.slave   bus,
  input  logic                flush_req,
  output logic                busy,
  output logic [CNT_W-1:0]    push_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  hold_t       r_hold;
  logic        r_push;
  logic [15:0] r_din;

  logic        w_busy;
  logic        w_space_ok;
  logic        w_push_fire;
  logic        w_in_ready;
  logic        w_accept;
  logic [15:0] w_push_data;

  assign w_busy = (r_state == FIRST) || (r_state == SECOND);

  // The FIFO flag lags a push by a cycle: with only one slot reported free,
  // a push is safe only if none is being presented to the FIFO right now.
  assign w_space_ok = (bus.PUSH_FLAG > FLAG_ONE) ||
                      ((bus.PUSH_FLAG == FLAG_ONE) && !r_push);

  // A flush request suppresses the push so no pending half leaks out.
  assign w_push_fire = w_busy && w_space_ok && !flush_req;

  // Ready is gated by Rst and flush_req so that no handshake completes in a
  // cycle whose word would be thrown away anyway.
  assign w_in_ready = !Rst && !flush_req &&
                      ((r_state == EMPTY) ||
                       ((r_state == SECOND) && w_push_fire) ||
                       ((r_state == FIRST) && r_hold.half && w_push_fire));

  assign w_accept = bus.in_valid && w_in_ready;

  assign w_push_data = (r_state == FIRST) ? pick_half(r_hold.data, HI_FIRST)
                                          : pick_half(r_hold.data, !HI_FIRST);

  always_comb begin
    w_state_nxt = r_state;
    if (flush_req) begin
      w_state_nxt = FLUSH;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) w_state_nxt = FIRST;
        end
        FIRST: begin
          if (w_push_fire) begin
            if (r_hold.half) w_state_nxt = w_accept ? FIRST : EMPTY;
            else             w_state_nxt = SECOND;
          end
        end
        SECOND: begin
          if (w_push_fire) w_state_nxt = w_accept ? FIRST : EMPTY;
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Control and FIFO write port registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= EMPTY;
      r_push  <= 1'b0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_push  <= w_push_fire;
      if (w_push_fire) r_din <= w_push_data;
    end
  end

  // Hold register: only meaningful while busy, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (w_accept) r_hold <= '{half: bus.in_half, data: bus.in_data};
  end

  sat_counter #(.CNT_W(CNT_W)) u_push_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .inc (w_push_fire),
    .clr (1'b0),
    .cnt (push_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .inc (w_busy && !w_space_ok),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

  assign bus.in_ready        = w_in_ready;
  assign bus.PUSH            = r_push;
  assign bus.DIN             = r_din;
  assign bus.Fifo_Push_Flush = (r_state == FLUSH);
  assign busy                = w_busy;

endmodule

// File: tb/tb_fifo_push_packer.sv
module tb_fifo_push_packer;

  localparam int CNT_W = 4;

  logic             Clk;
  logic             Rst;
  logic             flush_req;
  logic             busy;
  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] stall_cnt;

  fifo_push_packer_if bus();

  fifo_push_packer #(.HI_FIRST(1'b0), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .bus       (bus),
    .flush_req (flush_req),
    .busy      (busy),
    .push_cnt  (push_cnt),
    .stall_cnt (stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        chk;
    logic        rst;
    logic        vld;
    logic [31:0] dat;
    logic        e_rdy;
    logic        e_push;
    logic [15:0] e_din;
    logic        e_busy;
    logic [3:0]  e_pc;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after the rising edge, then stop on the
  // falling edge so the caller can sample outputs.
  task automatic cycle(input logic rst, input logic vld, input logic [31:0] dat,
                       input logic half, input logic fl, input logic [3:0] flag);
    @(posedge Clk);
    #1;
    Rst           = rst;
    bus.in_valid  = vld;
    bus.in_data   = dat;
    bus.in_half   = half;
    flush_req     = fl;
    bus.PUSH_FLAG = flag;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
  endtask

  initial begin
    Rst           = 1'b1;
    flush_req     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_half   = 1'b0;
    bus.PUSH_FLAG = 4'h8;

    //            chk   rst   vld   dat           rdy   push  din       busy  pc
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0,    1'b0, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0,    1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'hBEEFCAFE, 1'b1, 1'b0, 16'h0,    1'b0, 4'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0,    1'b1, 4'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 16'hCAFE, 1'b1, 4'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 16'hBEEF, 1'b0, 4'd2};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 16'hBEEF, 1'b0, 4'd2};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h00010002, 1'b1, 1'b0, 16'hBEEF, 1'b0, 4'd2};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h00030004, 1'b0, 1'b0, 16'hBEEF, 1'b1, 4'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h00030004, 1'b1, 1'b1, 16'h0002, 1'b1, 4'd3};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h0001, 1'b1, 4'd4};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 16'h0004, 1'b1, 4'd5};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 16'h0003, 1'b0, 4'd6};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 16'h0003, 1'b0, 4'd6};

    // Reset state, single word, then back-to-back words.
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].rst, vecs[i].vld, vecs[i].dat, 1'b0, 1'b0, 4'h8);
      if (vecs[i].chk) begin
        check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
        check($sformatf("v%0d PUSH", i), 32'(bus.PUSH), 32'(vecs[i].e_push));
        check($sformatf("v%0d DIN", i), 32'(bus.DIN), 32'(vecs[i].e_din));
        check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
        check($sformatf("v%0d push_cnt", i), 32'(push_cnt), 32'(vecs[i].e_pc));
        check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'd0);
        check($sformatf("v%0d flush", i), 32'(bus.Fifo_Push_Flush), 32'd0);
      end
    end

    // FIFO full for five cycles after an accept.
    do_reset();
    cycle(1'b0, 1'b1, 32'hAAAA5555, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
      check($sformatf("full%0d PUSH", i), 32'(bus.PUSH), 32'd0);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("full stall_cnt", 32'(stall_cnt), 32'd5);
    check("full rise PUSH", 32'(bus.PUSH), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("full first PUSH", 32'(bus.PUSH), 32'd1);
    check("full first DIN", 32'(bus.DIN), 32'h5555);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("full second DIN", 32'(bus.DIN), 32'hAAAA);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("full push_cnt", 32'(push_cnt), 32'd2);
    check("full busy", 32'(busy), 32'd0);

    // Exactly one slot free: pushes must be separated by a gap.
    do_reset();
    cycle(1'b0, 1'b1, 32'h11112222, 1'b0, 1'b0, 4'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h1);
    check("one f1 PUSH", 32'(bus.PUSH), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h1);
    check("one f2 PUSH", 32'(bus.PUSH), 32'd1);
    check("one f2 DIN", 32'(bus.DIN), 32'h2222);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h1);
    check("one f3 PUSH", 32'(bus.PUSH), 32'd0);
    check("one f3 DIN hold", 32'(bus.DIN), 32'h2222);
    check("one f3 stall_cnt", 32'(stall_cnt), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h1);
    check("one f4 PUSH", 32'(bus.PUSH), 32'd1);
    check("one f4 DIN", 32'(bus.DIN), 32'h1111);

    // Half word, next word accepted in the same cycle as its push decision.
    do_reset();
    cycle(1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 4'h8);
    cycle(1'b0, 1'b1, 32'h9ABCDEF0, 1'b0, 1'b0, 4'h8);
    check("half in_ready", 32'(bus.in_ready), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("half PUSH", 32'(bus.PUSH), 32'd1);
    check("half DIN", 32'(bus.DIN), 32'h5678);
    check("half busy", 32'(busy), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("half next lo", 32'(bus.DIN), 32'hDEF0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("half next hi", 32'(bus.DIN), 32'h9ABC);
    check("half push_cnt", 32'(push_cnt), 32'd3);

    // Flush while the second half is pending.
    do_reset();
    cycle(1'b0, 1'b1, 32'hCAFE0123, 1'b0, 1'b0, 4'h8);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    cycle(1'b0, 1'b1, 32'h55556666, 1'b0, 1'b1, 4'h8);
    check("flush req in_ready", 32'(bus.in_ready), 32'd0);
    check("flush req DIN", 32'(bus.DIN), 32'h0123);
    cycle(1'b0, 1'b1, 32'h77778888, 1'b0, 1'b0, 4'h8);
    check("flush Fifo_Push_Flush", 32'(bus.Fifo_Push_Flush), 32'd1);
    check("flush PUSH", 32'(bus.PUSH), 32'd0);
    check("flush in_ready", 32'(bus.in_ready), 32'd0);
    check("flush busy", 32'(busy), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("flush after flag", 32'(bus.Fifo_Push_Flush), 32'd0);
    check("flush after PUSH", 32'(bus.PUSH), 32'd0);
    check("flush push_cnt", 32'(push_cnt), 32'd1);
    check("flush after in_ready", 32'(bus.in_ready), 32'd1);

    // Flush in the same cycle as a would-be accept: word dropped.
    cycle(1'b0, 1'b1, 32'h9999AAAA, 1'b0, 1'b1, 4'h8);
    check("flush+acc in_ready", 32'(bus.in_ready), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("flush+acc busy", 32'(busy), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("flush+acc PUSH", 32'(bus.PUSH), 32'd0);

    // Rst while the second half is pending.
    do_reset();
    cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'h8);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("rst mid DIN", 32'(bus.DIN), 32'hBEEF);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("rst PUSH", 32'(bus.PUSH), 32'd0);
    check("rst DIN", 32'(bus.DIN), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst push_cnt", 32'(push_cnt), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    check("rst flush", 32'(bus.Fifo_Push_Flush), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h8);
    check("rst after PUSH", 32'(bus.PUSH), 32'd0);
    check("rst after busy", 32'(busy), 32'd0);

    // Stall counter saturation.
    do_reset();
    cycle(1'b0, 1'b1, 32'h01020304, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
    check("sat stall_cnt", 32'(stall_cnt), 32'd15);
    check("sat PUSH", 32'(bus.PUSH), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
